alarm_clock_ctrl: RTL and testbench

Hardware timekeeping and alarm controller for the alarm-clock design. It divides the system clock to a 1 Hz tick and keeps BCD hours/minutes/seconds. It runs a mode state machine driven by the mode switches and edit buttons, and rings the buzzer when the alarm time is reached. It drives the same switch, button and buzzer signals the processor system uses, so the time and alarm function exists in RTL. Seven-segment decoding is outside this block.

---
 rtl/alarm_clock_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_ctrl.sv
// Timekeeping and alarm controller: 1 Hz divider, BCD time/alarm registers,
// RUN / SET_TIME / SET_ALARM mode machine, edit buttons and buzzer ring timer.
module alarm_clock_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int RING_SECS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  sw_states,
    input  logic [1:0]  btn_edit,
    output logic [23:0] disp_bcd,
    output logic        edit_field,
    output logic        buzzer
);

    localparam int DIV_W  = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int RING_W = $clog2(RING_SECS + 1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_HZ - 1);
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } mode_t;

    mode_t             state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [7:0]        hours_reg, hours_next;
    logic [7:0]        mins_reg, mins_next;
    logic [7:0]        secs_reg, secs_next;
    logic [7:0]        alarm_h_reg, alarm_h_next;
    logic [7:0]        alarm_m_reg, alarm_m_next;
    logic              edit_field_reg, edit_field_next;
    logic              buzzer_reg, buzzer_next;
    logic [RING_W-1:0] ring_cnt_reg, ring_cnt_next;
    logic [23:0]       disp_reg, disp_next;
    logic [1:0]        btn_cur_reg, btn_prev_reg;
    logic [1:0]        press;
    logic              tick;
    logic              alarm_match;

    // Falling edge of the registered button sample; a held button yields one press.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_press
            assign press[gi] = btn_prev_reg[gi] & ~btn_cur_reg[gi];
        end
    endgenerate

    // Saturating comparisons keep the result legal BCD even from a bad value.
    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        if (v[3:0] >= 4'd9) begin
            if (v[7:4] >= 4'd5) return 8'h00;
            else                return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
        if (v[7:4] >= 4'd2 && v[3:0] >= 4'd3) return 8'h00;
        if (v[3:0] >= 4'd9)                   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_next      = RUN;
        div_next        = div_reg + DIV_W'(1);
        hours_next      = hours_reg;
        mins_next       = mins_reg;
        secs_next       = secs_reg;
        alarm_h_next    = alarm_h_reg;
        alarm_m_next    = alarm_m_reg;
        edit_field_next = edit_field_reg;
        buzzer_next     = buzzer_reg;
        ring_cnt_next   = ring_cnt_reg;
        tick            = (div_reg == DIV_MAX);

        if (sw_states[0])      state_next = SET_TIME;
        else if (sw_states[1]) state_next = SET_ALARM;

        if (tick) div_next = '0;

        if (state_reg == SET_TIME) begin
            secs_next = 8'h00;
            if (press[1]) begin
                if (edit_field_reg) mins_next  = inc_bcd60(mins_reg);
                else                hours_next = inc_bcd24(hours_reg);
            end
        end else if (tick) begin
            secs_next = inc_bcd60(secs_reg);
            if (secs_reg == 8'h59) begin
                mins_next = inc_bcd60(mins_reg);
                if (mins_reg == 8'h59) hours_next = inc_bcd24(hours_reg);
            end
        end

        if (state_reg == SET_ALARM && press[1]) begin
            if (edit_field_reg) alarm_m_next = inc_bcd60(alarm_m_reg);
            else                alarm_h_next = inc_bcd24(alarm_h_reg);
        end

        if (state_next != state_reg)              edit_field_next = 1'b0;
        else if (state_reg != RUN && press[0])    edit_field_next = ~edit_field_reg;

        // Only a tick can move the time onto the alarm in RUN, so one match per pass.
        alarm_match = tick && (state_reg == RUN) && sw_states[2] &&
                      ({hours_next, mins_next, secs_next} == {alarm_h_reg, alarm_m_reg, 8'h00});

        if (!sw_states[2] || state_next != RUN || (buzzer_reg && press[1])) begin
            buzzer_next   = 1'b0;
            ring_cnt_next = '0;
        end else if (alarm_match) begin
            buzzer_next   = 1'b1;
            ring_cnt_next = RING_LOAD;
        end else if (buzzer_reg && tick) begin
            ring_cnt_next = ring_cnt_reg - RING_W'(1);
            if (ring_cnt_reg <= RING_W'(1)) buzzer_next = 1'b0;
        end

        if (state_next == SET_ALARM) disp_next = {alarm_h_next, alarm_m_next, 8'h00};
        else                         disp_next = {hours_next, mins_next, secs_next};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= RUN;
            div_reg        <= '0;
            hours_reg      <= 8'h00;
            mins_reg       <= 8'h00;
            secs_reg       <= 8'h00;
            alarm_h_reg    <= 8'h00;
            alarm_m_reg    <= 8'h00;
            edit_field_reg <= 1'b0;
            buzzer_reg     <= 1'b0;
            ring_cnt_reg   <= '0;
            disp_reg       <= 24'h000000;
            btn_cur_reg    <= 2'b11;
            btn_prev_reg   <= 2'b11;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            hours_reg      <= hours_next;
            mins_reg       <= mins_next;
            secs_reg       <= secs_next;
            alarm_h_reg    <= alarm_h_next;
            alarm_m_reg    <= alarm_m_next;
            edit_field_reg <= edit_field_next;
            buzzer_reg     <= buzzer_next;
            ring_cnt_reg   <= ring_cnt_next;
            disp_reg       <= disp_next;
            btn_cur_reg    <= btn_edit;
            btn_prev_reg   <= btn_cur_reg;
        end
    end

    assign disp_bcd   = disp_reg;
    assign edit_field = edit_field_reg;
    assign buzzer     = buzzer_reg;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl with a 4-cycle second and a 3-second ring.
module tb_alarm_clock_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sw_states;
    logic [1:0]  btn_edit;
    logic [23:0] disp_bcd;
    logic        edit_field;
    logic        buzzer;

    int          checks = 0;
    int          errors = 0;
    int unsigned edges_since_rst = 0;

    alarm_clock_ctrl #(.CLK_HZ(4), .RING_SECS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_states  (sw_states),
        .btn_edit   (btn_edit),
        .disp_bcd   (disp_bcd),
        .edit_field (edit_field),
        .buzzer     (buzzer)
    );

    always #5 clk = ~clk;

    // Edges since reset release; an edge that makes this a multiple of 4 is a tick edge.
    always @(posedge clk) begin
        if (!reset) edges_since_rst <= 0;
        else        edges_since_rst <= edges_since_rst + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx);
        btn_edit[idx] = 1'b0;
        cyc(1);
        btn_edit[idx] = 1'b1;
        cyc(1);
    endtask

    task automatic tick_wait(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clk);
            if (edges_since_rst % 4 == 0) k++;
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        logic [23:0] wrap_seq [3];
        int          idx;
        wrap_seq[0] = 24'h235958;
        wrap_seq[1] = 24'h235959;
        wrap_seq[2] = 24'h000000;

        reset     = 1'b0;
        sw_states = 3'b000;
        btn_edit  = 2'b11;
        cyc(2);
        $display("step reset");
        chk("rst_disp", disp_bcd, 24'h000000);
        chk_bit("rst_edit", edit_field, 1'b0);
        chk_bit("rst_buzz", buzzer, 1'b0);
        reset = 1'b1;

        $display("step edit_wrap");
        sw_states = 3'b001;
        cyc(1);
        chk("st_enter_disp", disp_bcd, 24'h000000);
        chk_bit("st_enter_edit", edit_field, 1'b0);
        repeat (23) press(1);
        chk("hours_23", disp_bcd, 24'h230000);
        press(1);
        chk("hours_wrap", disp_bcd, 24'h000000);
        press(0);
        chk_bit("toggle_min", edit_field, 1'b1);
        repeat (59) press(1);
        chk("mins_59", disp_bcd, 24'h005900);
        btn_edit[1] = 1'b0;
        cyc(6);
        btn_edit[1] = 1'b1;
        cyc(2);
        chk("held_wrap", disp_bcd, 24'h000000);
        press(0);
        repeat (23) press(1);
        press(0);
        repeat (59) press(1);
        chk("load_2359", disp_bcd, 24'h235900);

        $display("step run_wrap");
        sw_states = 3'b000;
        cyc(1);
        chk_bit("run_edit_clr", edit_field, 1'b0);
        chk("run_start", disp_bcd, 24'h235900);
        tick_wait(58);
        idx = 0;
        chk("wrap_58", disp_bcd, wrap_seq[0]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (edges_since_rst % 4 == 0) idx++;
            chk("wrap_seq", disp_bcd, wrap_seq[idx]);
        end
        chk_bit("wrap_buzz", buzzer, 1'b0);

        $display("step alarm_ring");
        sw_states = 3'b010;
        cyc(1);
        chk("sa_disp", disp_bcd, 24'h000000);
        press(0);
        chk_bit("sa_edit", edit_field, 1'b1);
        cyc(3);
        press(1);
        chk("sa_alarm_0001", disp_bcd, 24'h000100);
        sw_states = 3'b100;
        cyc(1);
        chk("sa_time_counted", disp_bcd, 24'h000002);
        tick_wait(57);
        chk("pre_ring_disp", disp_bcd, 24'h000059);
        chk_bit("pre_ring_buzz", buzzer, 1'b0);
        cyc(3);
        chk_bit("pre_ring_buzz2", buzzer, 1'b0);
        cyc(1);
        chk("ring_disp", disp_bcd, 24'h000100);
        chk_bit("ring_rise", buzzer, 1'b1);
        tick_wait(2);
        chk_bit("ring_hold", buzzer, 1'b1);
        cyc(3);
        chk_bit("ring_last", buzzer, 1'b1);
        cyc(1);
        chk("ring_end_disp", disp_bcd, 24'h000103);
        chk_bit("ring_fall", buzzer, 1'b0);

        $display("step dismiss");
        sw_states = 3'b110;
        cyc(1);
        press(0);
        press(1);
        chk("alarm_0002", disp_bcd, 24'h000200);
        sw_states = 3'b100;
        cyc(1);
        chk("run_0104", disp_bcd, 24'h000104);
        chk_bit("run_edit_clr2", edit_field, 1'b0);
        tick_wait(56);
        chk("ring2_disp", disp_bcd, 24'h000200);
        chk_bit("ring2_rise", buzzer, 1'b1);
        btn_edit[1] = 1'b0;
        cyc(1);
        chk_bit("dismiss_1edge", buzzer, 1'b1);
        btn_edit[1] = 1'b1;
        cyc(1);
        chk_bit("dismiss_2edge", buzzer, 1'b0);
        chk("dismiss_disp", disp_bcd, 24'h000200);

        $display("step disable");
        sw_states = 3'b110;
        cyc(1);
        press(0);
        press(1);
        chk("alarm_0003", disp_bcd, 24'h000300);
        sw_states = 3'b100;
        cyc(1);
        chk("run_0202", disp_bcd, 24'h000202);
        tick_wait(58);
        chk("ring3_disp", disp_bcd, 24'h000300);
        chk_bit("ring3_rise", buzzer, 1'b1);
        cyc(1);
        chk_bit("ring3_hold", buzzer, 1'b1);
        sw_states = 3'b000;
        cyc(1);
        chk_bit("disable_fall", buzzer, 1'b0);

        $display("step priority");
        sw_states = 3'b010;
        cyc(1);
        press(1);
        chk("alarm_0103", disp_bcd, 24'h010300);
        press(0);
        press(1);
        chk("alarm_0104", disp_bcd, 24'h010400);
        sw_states = 3'b011;
        cyc(2);
        chk("prio_secs_zero", disp_bcd, 24'h000300);
        chk_bit("prio_edit_clr", edit_field, 1'b0);
        cyc(8);
        chk("prio_frozen", disp_bcd, 24'h000300);
        press(1);
        chk("prio_hours_inc", disp_bcd, 24'h010300);
        sw_states = 3'b100;
        cyc(1);
        chk("prio_run_time", disp_bcd, 24'h010300);

        $display("step reset_mid_ring");
        tick_wait(60);
        chk("ring4_disp", disp_bcd, 24'h010400);
        chk_bit("ring4_rise", buzzer, 1'b1);
        tick_wait(1);
        chk_bit("ring4_hold", buzzer, 1'b1);
        reset = 1'b0;
        cyc(1);
        chk_bit("mid_rst_buzz", buzzer, 1'b0);
        chk("mid_rst_disp", disp_bcd, 24'h000000);
        chk_bit("mid_rst_edit", edit_field, 1'b0);
        reset     = 1'b1;
        sw_states = 3'b010;
        cyc(1);
        chk("mid_rst_alarm", disp_bcd, 24'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
